mem_stage_accept: RTL
=====================

// Module: mem_stage_accept
// PURPOSE
//  MEM-stage receiving end of the EXE->MEM valid/allow_in handshake. Drives mem_allow_in,
//  latches the EXE->MEM bus, tracks one outstanding data_sram response (data_ok), and hands
//  finished instructions to WB under wb_allow_in back-pressure. Also handles flush, and the
//  draining of a cancelled in-flight memory request. Sits between the EXE stage and WB.
// PARAMETERS
//  BUS_W     150   width of exe_to_mem_bus / mem_to_wb_bus
//  DATA_W    32    data_sram read data width
// PORTS
//  clk               in   1       clock
//  rst               in   1       reset, synchronous, active-high
//  flush             in   1       exception/ertn cancel of the MEM-stage instruction
//  exe_to_mem_valid  in   1       EXE holds a finished instruction (already gated by EXE ready_go)
//  exe_to_mem_bus    in   BUS_W   EXE payload
//  exe_mem_req       in   1       the offered instruction has issued a data_sram request
//  mem_allow_in      out  1       MEM accepts an instruction this cycle
//  data_sram_data_ok in   1       response strobe for the outstanding request
//  data_sram_rdata   in   DATA_W  response data, valid with data_ok
//  wb_allow_in       in   1       WB accepts an instruction this cycle
//  mem_to_wb_valid   out  1       MEM offers an instruction to WB
//  mem_to_wb_bus     out  BUS_W   latched payload
//  mem_rdata         out  DATA_W  load data for the offered instruction (0 for non-memory ops)
//  mem_busy          out  1       a data_sram response is outstanding (WAIT or DROP)
// BEHAVIOUR
//  States: EMPTY, WAIT (response pending), READY (result held), DROP (cancelled, draining).
//  Reset: state=EMPTY; bus reg=0; rdata reg=0; mem_to_wb_valid=0; mem_busy=0; mem_allow_in=1.
//  mem_ready_go = (state==READY) [| (state==WAIT & data_ok) when the bypass is enabled].
//  mem_allow_in = (state==EMPTY) | (mem_ready_go & wb_allow_in); forced 0 in DROP and when flush=1.
//  mem_to_wb_valid = mem_ready_go & ~flush. WB transfer = mem_to_wb_valid & wb_allow_in.
//  Accept = exe_to_mem_valid & mem_allow_in: latch bus; next=WAIT if exe_mem_req, else READY
//   (rdata reg cleared to 0). Accept while transferring to WB = back-to-back; no bubble.
//  EMPTY: accept -> WAIT/READY; otherwise hold.
//  WAIT: data_ok -> capture rdata, go READY (or leave directly via the bypass, see CONFIGURATION).
//   No data_ok -> hold; mem_allow_in=0.
//  READY: WB transfer & no accept -> EMPTY; WB transfer & accept -> WAIT/READY; else hold
//   (bus and rdata stable while mem_to_wb_valid=1 & wb_allow_in=0).
//  Flush (highest priority): EMPTY/READY -> EMPTY; WAIT without data_ok -> DROP; WAIT with data_ok
//   -> EMPTY (response discarded). No accept and no WB transfer in a flush cycle.
//  DROP: data_ok -> EMPTY, data discarded; else hold. Flush in DROP has no further effect.
//  data_ok outside WAIT/DROP is a protocol error; it is ignored (state and regs unchanged).
//  Exactly one outstanding request is tracked; EXE never issues a second request while mem_busy=1.
//  rst in any state (incl. WAIT/DROP) returns to EMPTY; the outstanding response is not drained.
// CONFIGURATION
//  MEM_RESP_BYPASS_EN defined: in WAIT, data_ok & wb_allow_in forwards data_sram_rdata
//   combinationally onto mem_rdata with mem_to_wb_valid=1 in the same cycle, then goes to
//   EMPTY/accept; load costs 0 extra cycles after data_ok.
//  Undefined: data_ok always registers into the rdata reg and moves to READY; mem_to_wb_valid
//   rises the next cycle (+1 cycle per load), and there is no combinational path from sram to WB.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> mem_allow_in=1, mem_to_wb_valid=0, mem_busy=0, buses 0.
//  T2 ALU stream: valid=1, exe_mem_req=0, wb_allow_in=1, bus=1..5 on consecutive cycles ->
//   mem_to_wb_bus=1..5 one cycle later each, mem_allow_in stays 1, no bubbles.
//  T3 load: accept with exe_mem_req=1, data_ok 3 cycles later with rdata=32'hDEADBEEF ->
//   mem_allow_in=0 and mem_busy=1 while waiting; mem_rdata=DEADBEEF on the data_ok cycle
//   (bypass) or the next cycle (no bypass).
//  T4 WB stall: READY with wb_allow_in=0 for 4 cycles -> bus/rdata stable, mem_allow_in=0,
//   new EXE offer not accepted; wb_allow_in=1 -> transfer and accept in the same cycle.
//  T5 flush in WAIT: flush=1, then data_ok=1 two cycles later with rdata=32'h1234 ->
//   mem_to_wb_valid never 1, mem_allow_in=0 until data_ok, EMPTY after, mem_busy falls.
//  T6 flush+data_ok same cycle in WAIT -> EMPTY next cycle, mem_busy=0, no WB transfer.

Source files
------------

// File: rtl/mem_stage_accept.sv
// MEM stage: accepts EXE->MEM instructions, tracks one outstanding data_sram response and hands
// results to WB. Define MEM_RESP_BYPASS_EN to forward a response to WB in its data_ok cycle.
module mem_stage_accept #(
   parameter int BUS_W  = 150,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              exe_to_mem_valid,
   input  logic [BUS_W-1:0]  exe_to_mem_bus,
   input  logic              exe_mem_req,
   output logic              mem_allow_in,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   input  logic              wb_allow_in,
   output logic              mem_to_wb_valid,
   output logic [BUS_W-1:0]  mem_to_wb_bus,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_busy,
   output logic [1:0]        mem_state_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2,
      DROP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BUS_W-1:0]    bus_q, bus_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ready_go;
   logic                accept;
   logic                wb_xfer;

   // Handshake: an instruction moves EXE->MEM when exe_to_mem_valid & mem_allow_in, and
   // MEM->WB when mem_to_wb_valid & wb_allow_in, both sampled at the same rising clk edge.
`ifdef MEM_RESP_BYPASS_EN
   assign ready_go  = (state_q == READY) | ((state_q == WAIT) & data_sram_data_ok);
   assign mem_rdata = ((state_q == WAIT) & data_sram_data_ok) ? data_sram_rdata : rdata_q;
`else
   assign ready_go  = (state_q == READY);
   assign mem_rdata = rdata_q;
`endif

   assign mem_allow_in    = ~flush & (state_q != DROP) &
                            ((state_q == EMPTY) | (ready_go & wb_allow_in));
   assign mem_to_wb_valid = ready_go & ~flush;
   assign wb_xfer         = mem_to_wb_valid & wb_allow_in;
   assign accept          = exe_to_mem_valid & mem_allow_in;
   assign mem_to_wb_bus   = bus_q;
   assign mem_busy        = (state_q == WAIT) | (state_q == DROP);
   assign mem_state_o     = state_q;

   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      rdata_d = rdata_q;
      if (flush) begin
         // A pending response must still be drained unless it arrives in this very cycle.
         unique case (state_q)
            EMPTY, READY: state_d = EMPTY;
            WAIT, DROP:   state_d = data_sram_data_ok ? EMPTY : DROP;
         endcase
      end else begin
         unique case (state_q)
            EMPTY: state_d = EMPTY;
            WAIT: begin
               if (data_sram_data_ok) begin
`ifdef MEM_RESP_BYPASS_EN
                  if (wb_allow_in) begin
                     state_d = EMPTY;
                  end else begin
                     rdata_d = data_sram_rdata;
                     state_d = READY;
                  end
`else
                  rdata_d = data_sram_rdata;
                  state_d = READY;
`endif
               end
            end
            READY: if (wb_xfer) state_d = EMPTY;
            DROP:  if (data_sram_data_ok) state_d = EMPTY;
         endcase
         // Accept overrides the vacate above, giving back-to-back flow with no bubble.
         if (accept) begin
            bus_d   = exe_to_mem_bus;
            rdata_d = '0;
            state_d = exe_mem_req ? WAIT : READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         bus_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
